// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder.
//  - default character width and queue depth
//  - feeder FSM state encoding (IDLE / LOAD / WAIT)
//  - baud constants shared by the UART blocks
//  - small helper to classify FSM states
package uart_tx_feeder_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;

  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 115_200;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } feeder_state_e;

  // A frame is owned by the feeder from the pop until tx_done returns it to IDLE.
  function automatic logic frame_active(input feeder_state_e st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Synchronous FIFO used as the byte queue in front of the UART transmitter.
// Ports:
//  clk, rst       clock, asynchronous active-high reset
//  push, din      write request and data (ignored when full or flushing)
//  pop            read request; head advances (ignored when empty or flushing)
//  flush          synchronous clear of pointers and occupancy
//  dout           current head entry
//  count          occupancy 0..DEPTH
//  full, empty    occupancy flags derived from count
module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q,  count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Flush dominates both ports; a full queue rejects a push even if a pop
  // happens the same cycle (the freed slot is only visible next cycle).
  assign push_ok = push & ~full  & ~flush;
  assign pop_ok  = pop  & ~empty & ~flush;

  // Next pointer / occupancy computation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered front end for the UART transmitter.
// Bytes arrive on a valid/ready port, are queued in sync_fifo, and are handed
// to the transmitter one at a time (tx_start pulse + stable tx_data), waiting
// for the transmitter's tx_done pulse before issuing the next one.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  wr_valid/wr_data    host write offer
//  wr_ready            queue can accept (count != DEPTH)
//  flush               drop all queued bytes; an in-flight frame completes
//  tx_start, tx_data   transmitter start pulse and character
//  tx_done             transmitter end-of-frame pulse
//  busy                frame in flight or queue non-empty
//  count               queue occupancy
//  overflow            sticky: write offered while wr_ready was low
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  flush,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [AW:0]           count,
  output logic                  overflow
);

  feeder_state_e         state_q,    state_d;
  logic [DATA_WIDTH-1:0] tx_data_q,  tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  overflow_q, overflow_d;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .din   (wr_data),
    .pop   (fifo_pop),
    .flush (flush),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_ready = ~fifo_full;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign busy     = frame_active(state_q) | ~fifo_empty;

  // Feeder FSM: next state, head pop and registered start/data values.
  // A pop is suppressed in a flush cycle so the flushed head is discarded
  // rather than launched.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !flush) begin
          fifo_pop  = 1'b1;
          tx_data_d = fifo_dout;
          state_d   = ST_LOAD;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // tx_start is registered, so it is high during the first WAIT cycle.
        tx_start_d = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky overflow flag; flush clears it with priority over a new overflow.
  always_comb begin
    overflow_d = overflow_q;
    if (flush) begin
      overflow_d = 1'b0;
    end else if (wr_valid && fifo_full) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a transmitter stub that returns
// tx_done 50 unstalled cycles after each tx_start. A queue-based reference
// model predicts every output on every cycle.
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          flush;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_done;
  logic          busy;
  logic [AW:0]   count;
  logic          overflow;

  always #10 clk = ~clk;

  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .flush    (flush),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .count    (count),
    .overflow (overflow)
  );

  // Reference model: queued bytes, frame phase (0 none, 1 popped, 2 on the wire)
  logic [DW-1:0] mq[$];
  int            ph;
  logic [DW-1:0] m_data;
  bit            m_ovf;
  bit            m_start;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            stub_cnt = -1;
  bit            stall = 1'b0;
  int            n_starts = 0;
  int            last_start_cyc = 0;
  logic [DW-1:0] start_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ph      = 0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_start = 1'b0;
  endtask

  // One clock edge of the reference behaviour using the inputs seen at that edge.
  task automatic model_step();
    bit rdy;
    rdy     = (mq.size() != DEPTH);
    m_start = (ph == 1);
    if (ph == 2) begin
      if (tx_done) ph = 0;
    end else if (ph == 1) begin
      ph = 2;
    end else if (mq.size() != 0 && !flush) begin
      m_data = mq.pop_front();
      ph     = 1;
    end
    if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (wr_valid) begin
      if (rdy) mq.push_back(wr_data);
      else     m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("count",    32'(count),    32'(mq.size()));
    check("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
    check("busy",     32'(busy),     32'((ph != 0) || (mq.size() != 0)));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tx_start", 32'(tx_start), 32'(m_start));
    check("tx_data",  32'(tx_data),  32'(m_data));
  endtask

  // Advance one clock: update model, compare, then run the transmitter stub.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
    tx_done = 1'b0;
    if (rst) begin
      stub_cnt = -1;
    end else begin
      if (tx_start === 1'b1) begin
        n_starts++;
        start_log.push_back(tx_data);
        last_start_cyc = cyc;
        stub_cnt = 50;
      end else if (stub_cnt > 0 && !stall) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          tx_done  = 1'b1;
          stub_cnt = -1;
        end
      end
    end
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((ph != 0 || mq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'((ph != 0) || (mq.size() != 0)), 32'd0);
  endtask

  task automatic wait_on_wire(input int budget);
    int n;
    n = 0;
    while (ph != 2 && n < budget) begin
      tick();
      n++;
    end
    check("wire_timeout", 32'(ph), 32'd2);
  endtask

  initial begin
    int n_wr;
    int s0;
    bit saw_aa;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0; tx_done = 1'b0;
    model_reset();
    tick();
    // reset values pinned to literals
    check("rst_count",    32'(count),    32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single byte, latency and data
    push_byte(8'h55);
    n_wr = cyc;
    for (int i = 0; i < 10 && n_starts == 0; i++) tick();
    check("t1_start_seen", 32'(n_starts), 32'd1);
    check("t1_latency", 32'(last_start_cyc - n_wr), 32'd2);
    check("t1_byte", 32'(start_log[0]), 32'h55);
    wait_idle(200);
    check("t1_busy_low", 32'(busy), 32'd0);

    // 2: burst 0x01..0x11 (one goes in flight, sixteen fill the queue)
    s0 = n_starts;
    for (int i = 1; i <= 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(i);
      tick();
    end
    wr_valid = 1'b0;
    check("t2_full_count", 32'(count), 32'd16);
    check("t2_full_ready", 32'(wr_ready), 32'd0);
    wait_idle(3000);
    check("t2_nstarts", 32'(n_starts - s0), 32'd17);
    for (int i = 0; i < 17; i++)
      check("t2_order", 32'(start_log[s0 + i]), 32'(i + 1));

    // 3: overflow with stalled transmitter
    stall = 1'b1;
    for (int i = 0; i < 17; i++) push_byte(DW'(8'h40 + i));
    check("t3_full", 32'(count), 32'd16);
    push_byte(8'hAA);
    check("t3_overflow_set", 32'(overflow), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_overflow_clr", 32'(overflow), 32'd0);
    check("t3_flush_count", 32'(count), 32'd0);
    stall = 1'b0;
    wait_idle(200);
    saw_aa = 1'b0;
    foreach (start_log[i]) if (start_log[i] == 8'hAA) saw_aa = 1'b1;
    check("t3_no_aa", 32'(saw_aa), 32'd0);

    // 4: flush while the first of three bytes is on the wire
    s0 = n_starts;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    wait_on_wire(20);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_count", 32'(count), 32'd0);
    wait_idle(200);
    check("t4_nstarts", 32'(n_starts - s0), 32'd1);
    check("t4_byte", 32'(start_log[s0]), 32'h11);

    // 5: asynchronous reset mid-frame
    push_byte(8'h77);
    push_byte(8'h78);
    wait_on_wire(20);
    tick(); tick();
    #3;
    rst = 1'b1;
    #1;
    check("t5_count",    32'(count),    32'd0);
    check("t5_wr_ready", 32'(wr_ready), 32'd1);
    check("t5_tx_start", 32'(tx_start), 32'd0);
    check("t5_tx_data",  32'(tx_data),  32'd0);
    check("t5_busy",     32'(busy),     32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    s0 = n_starts;
    push_byte(8'h3C);
    wait_idle(200);
    check("t5_nstarts", 32'(n_starts - s0), 32'd1);
    check("t5_byte", 32'(start_log[start_log.size() - 1]), 32'h3C);

    // random traffic: writes, flushes and transmitter stalls
    for (int i = 0; i < 4000; i++) begin
      wr_valid = ($urandom_range(0, 99) < 40);
      wr_data  = DW'($urandom);
      flush    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) stall = ~stall;
      tick();
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    wait_idle(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
